pdm_serializer: RTL and testbench
=================================

// Module: pdm_serializer
// PURPOSE
//  Audio-output counterpart of the microphone PDM input path: accepts signed PCM samples over a
//  valid/ready handshake and drives a 1-bit PDM stream from a first-order sigma-delta modulator.
//  Sits between the audio processing/AXI side and the board's mono amplifier pin; also emits a
//  bit clock so it can drive a PDM-input codec. One sample is consumed every OSR bit periods.
// PARAMETERS
//  DATA_WIDTH            16      PCM sample width, two's complement
//  SYS_CLK_FREQ_MHZ      100     HCLK frequency
//  SAMPLING_CLK_FREQ_HZ  44100   nominal audio sample rate
//  OSR                   32      PDM bits per sample (power of 2, >=4)
//  localparam TICK_DIV = (SYS_CLK_FREQ_MHZ*1000000)/(SAMPLING_CLK_FREQ_HZ*OSR) - 1  (=69 at defaults)
//  localparam HALF     = (TICK_DIV+1)/2
// PORTS
//  HCLK       in   1           system clock
//  HRESETn    in   1           asynchronous, active-low reset
//  EN         in   1           block enable; low = synchronous clear to IDLE
//  s_data     in   DATA_WIDTH  PCM sample
//  s_valid    in   1           s_data valid
//  s_ready    out  1           holding buffer empty; transfer when s_valid & s_ready
//  sample_req out  1           1-cycle pulse at each sample boundary (cur sample reloaded)
//  underrun   out  1           1-cycle pulse: RUN-state boundary with empty buffer
//  pdm_out    out  1           PDM bitstream
//  pdm_clk    out  1           bit clock; pdm_out stable around rising edge
//  aud_sd     out  1           amplifier enable = registered EN
// BEHAVIOUR
//  Reset (HRESETn=0): all outputs 0, acc=0, buf empty, cur_sample=0, counters 0, state IDLE.
//  States: IDLE (EN=0) -> PRIME on EN=1; PRIME -> RUN at first boundary with buf full; RUN/PRIME -> IDLE
//   whenever EN=0 (next edge: same values as reset, buffered sample discarded). s_ready=0 in IDLE.
//  Bit timing: clk_cnt 0..TICK_DIV, wraps; tick when clk_cnt==TICK_DIV (bit period TICK_DIV+1 HCLKs).
//   On tick: modulator steps, pdm_out<=carry, pdm_clk<=0. At clk_cnt==HALF-1: pdm_clk<=1.
//  Modulator: off = s ^ (1<<(DATA_WIDTH-1)) (offset binary); {carry,acc} = acc + off, DATA_WIDTH+1 bits;
//   acc keeps low DATA_WIDTH bits, no saturation. Ones density = off/2^DATA_WIDTH.
//  bit_cnt 0..OSR-1 increments on tick; boundary = tick & bit_cnt==OSR-1. The boundary step uses the
//   old cur_sample; the new one applies from the next tick. sample_req pulses on the boundary cycle.
//  Boundary, buf full: cur_sample<=buf, buf empty. Buf empty: cur_sample held (repeat), underrun=1
//   only in RUN; PRIME keeps cur_sample=0 (midscale, 0101.. pattern), no underrun.
//  Handshake: s_ready = state!=IDLE & ~buf_full (registered). Accept in boundary cycle while empty:
//   the boundary still sees empty (underrun if RUN), buf becomes full with s_data. Latency first
//   accepted sample -> affects pdm_out: up to OSR bit periods + 1 tick.
//  EN deasserted mid-sample: truncates immediately; no partial-sample completion.
// STRUCTURE
//  Shared audio package: DATA_WIDTH default, TICK_DIV/HALF computation function, state encoding
//   (IDLE/PRIME/RUN). Natural sub-module: sd_modulator_1st (acc + carry, step enable, sync clear).
//  Top: tick/pdm_clk divider, bit counter, FSM, one-entry holding buffer.
// TESTING
//  Reset mid-run with EN=1 -> all outputs 0 same cycle; after release s_ready=1 within 2 cycles.
//  Feed 16'h0000 -> after PRIME->RUN, pdm_out alternates 0,1,0,1 (16 ones per 32 bits).
//  Feed 16'h8000 -> pdm_out constant 0; feed 16'h7FFF -> >=31 ones in each 32-bit window.
//  Feed one sample then stop -> underrun pulses once per 32*70 HCLKs, pdm pattern unchanged.
//  Hold s_valid with 3 samples (0x1000,0x2000,0x3000) -> s_ready low between boundaries,
//   one accept per sample_req, applied in order; no underrun.
//  Drop EN during bit 10 of a sample -> next edge pdm_out=0, aud_sd=0, s_ready=0, acc=0; re-enable -> PRIME.

Source files
------------

// File: rtl/pdm_serializer_pkg.sv
// Shared definitions for the PDM audio output path: default sample width,
// bit-clock divider arithmetic and the serializer state encoding.
package pdm_serializer_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Terminal count of the HCLK divider that produces one PDM bit period.
  function automatic int calc_tick_div(input int sys_mhz, input int fs_hz, input int osr);
    return (sys_mhz * 1000000) / (fs_hz * osr) - 1;
  endfunction

  function automatic int calc_half(input int tick_div);
    return (tick_div + 1) / 2;
  endfunction

endpackage

// File: rtl/pdm_serializer_if.sv
// PCM sample stream into the PDM serializer plus its per-sample status pulses.
interface pdm_serializer_if
  import pdm_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  sample_req;
  logic                  underrun;

  modport master (output s_data, s_valid, input s_ready, sample_req, underrun);
  modport slave  (input s_data, s_valid, output s_ready, sample_req, underrun);
endinterface

// File: rtl/pdm_serializer_sd_modulator_1st.sv
// First-order sigma-delta modulator: the accumulator carry is the PDM bit,
// so the ones density equals the offset-binary sample over 2^DATA_WIDTH.
module pdm_serializer_sd_modulator_1st
  import pdm_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  i_clr,
  input  logic                  i_step,
  input  logic [DATA_WIDTH-1:0] i_sample,
  output logic                  o_bit
);
  localparam logic [DATA_WIDTH-1:0] SIGN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_bit;
  logic [DATA_WIDTH:0]   w_sum;

  // Flipping the sign bit maps two's complement onto offset binary.
  assign w_sum = {1'b0, r_acc} + {1'b0, i_sample ^ SIGN};
  assign o_bit = r_bit;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_acc <= '0;
      r_bit <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_bit <= 1'b0;
    end else if (i_step) begin
      r_acc <= w_sum[DATA_WIDTH-1:0];
      r_bit <= w_sum[DATA_WIDTH];
    end
  end

endmodule

// File: rtl/pdm_serializer.sv
// PCM-to-PDM serializer: bit-clock divider, per-sample bit counter, IDLE/PRIME/RUN
// control and a one-entry holding buffer in front of the sigma-delta modulator.
module pdm_serializer
  import pdm_serializer_pkg::*;
#(
  parameter int DATA_WIDTH           = DATA_WIDTH_DEF,
  parameter int SYS_CLK_FREQ_MHZ     = 100,
  parameter int SAMPLING_CLK_FREQ_HZ = 44100,
  parameter int OSR                  = 32
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             EN,
  pdm_serializer_if.slave  bus,
  output logic             pdm_out,
  output logic             pdm_clk,
  output logic             aud_sd
);
  localparam int TICK_DIV = calc_tick_div(SYS_CLK_FREQ_MHZ, SAMPLING_CLK_FREQ_HZ, OSR);
  localparam int HALF     = calc_half(TICK_DIV);
  localparam int CNT_W    = $clog2(TICK_DIV + 1);
  localparam int BIT_W    = $clog2(OSR);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

  state_e                r_state;
  logic [CNT_W-1:0]      r_clk_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  r_buf_full;
  logic [DATA_WIDTH-1:0] r_cur;
  logic                  r_s_ready;
  logic                  r_sample_req;
  logic                  r_underrun;
  logic                  r_pdm_clk;
  logic                  r_aud_sd;

  logic w_active;
  logic w_tick;
  logic w_boundary;
  logic w_accept;
  logic w_buf_full_nxt;
  logic w_pdm_bit;

  assign w_active       = (r_state != ST_IDLE);
  assign w_tick         = w_active & (r_clk_cnt == CNT_LAST);
  assign w_boundary     = w_tick & (r_bit_cnt == BIT_LAST);
  assign w_accept       = bus.s_valid & r_s_ready;
  // The boundary frees the buffer; an accept can only land while it is empty.
  assign w_buf_full_nxt = (r_buf_full & ~w_boundary) | w_accept;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= ST_IDLE;
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_buf        <= '0;
      r_buf_full   <= 1'b0;
      r_cur        <= '0;
      r_s_ready    <= 1'b0;
      r_sample_req <= 1'b0;
      r_underrun   <= 1'b0;
      r_pdm_clk    <= 1'b0;
      r_aud_sd     <= 1'b0;
    end else begin
      r_aud_sd <= EN;
      if (!EN) begin
        r_state      <= ST_IDLE;
        r_clk_cnt    <= '0;
        r_bit_cnt    <= '0;
        r_buf        <= '0;
        r_buf_full   <= 1'b0;
        r_cur        <= '0;
        r_s_ready    <= 1'b0;
        r_sample_req <= 1'b0;
        r_underrun   <= 1'b0;
        r_pdm_clk    <= 1'b0;
      end else if (r_state == ST_IDLE) begin
        r_state   <= ST_PRIME;
        r_s_ready <= 1'b1;
      end else begin
        r_clk_cnt <= w_tick ? '0 : r_clk_cnt + 1'b1;
        if (w_tick) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_pdm_clk <= 1'b0;
        end else if (r_clk_cnt == CNT_RISE) begin
          r_pdm_clk <= 1'b1;
        end
        r_sample_req <= w_boundary;
        r_underrun   <= w_boundary & ~r_buf_full & (r_state == ST_RUN);
        // PRIME keeps emitting midscale until the first real sample is loaded.
        if (w_boundary & r_buf_full) begin
          r_cur   <= r_buf;
          r_state <= ST_RUN;
        end
        if (w_accept) r_buf <= bus.s_data;
        r_buf_full <= w_buf_full_nxt;
        r_s_ready  <= ~w_buf_full_nxt;
      end
    end
  end

  pdm_serializer_sd_modulator_1st #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mod (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .i_clr    (~EN),
    .i_step   (w_tick),
    .i_sample (r_cur),
    .o_bit    (w_pdm_bit)
  );

  assign bus.s_ready    = r_s_ready;
  assign bus.sample_req = r_sample_req;
  assign bus.underrun   = r_underrun;
  assign pdm_out        = w_pdm_bit;
  assign pdm_clk        = r_pdm_clk;
  assign aud_sd         = r_aud_sd;

endmodule

// File: tb/tb_pdm_serializer.sv
// Bench for pdm_serializer: a time-indexed model of the PDM stream checked every
// cycle, plus directed windows with hand-derived ones counts and random traffic.
module tb_pdm_serializer;
  localparam int DW    = 16;
  localparam int SYS   = 100;
  localparam int FS    = 44100;
  localparam int OSR   = 32;
  localparam int TD    = (SYS * 1000000) / (FS * OSR) - 1;
  localparam int D     = TD + 1;
  localparam int HALF  = D / 2;
  localparam int SPER  = D * OSR;
  localparam int MOD   = 1 << DW;
  localparam int MID   = 1 << (DW - 1);
  localparam int LIMIT = 95000;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  logic EN      = 1'b0;
  logic pdm_out, pdm_clk, aud_sd;

  pdm_serializer_if #(.DATA_WIDTH(DW)) bus ();

  pdm_serializer #(
    .DATA_WIDTH(DW), .SYS_CLK_FREQ_MHZ(SYS), .SAMPLING_CLK_FREQ_HZ(FS), .OSR(OSR)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .EN(EN), .bus(bus),
    .pdm_out(pdm_out), .pdm_clk(pdm_clk), .aud_sd(aud_sd)
  );

  always #5 HCLK = ~HCLK;

  // Model: time since enable gives bit phase and bit index; accumulator kept as an integer.
  bit m_on = 0, m_run = 0, m_full = 0;
  int m_t = 0, m_acc = 0, m_cur = 0, m_buf = 0;
  bit e_ready = 0, e_req = 0, e_und = 0, e_pdm = 0, e_clk = 0, e_aud = 0;

  int ph, sum_m;
  bit tick_m, bnd_m, acc_m, full_n;
  assign ph     = m_t % D;
  assign tick_m = (ph == TD);
  assign bnd_m  = tick_m && ((m_t / D) % OSR == OSR - 1);
  assign sum_m  = m_acc + m_cur + MID;
  assign acc_m  = bus.s_valid && e_ready;
  assign full_n = (m_full && !bnd_m) || acc_m;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn || !EN) begin
      m_on <= 0; m_run <= 0; m_full <= 0; m_t <= 0; m_acc <= 0; m_cur <= 0; m_buf <= 0;
      e_ready <= 0; e_req <= 0; e_und <= 0; e_pdm <= 0; e_clk <= 0;
      e_aud <= HRESETn ? EN : 1'b0;
    end else if (!m_on) begin
      e_aud <= 1'b1; m_on <= 1; m_t <= 0; e_ready <= 1;
    end else begin
      e_aud <= 1'b1;
      if (tick_m) begin
        e_pdm <= (sum_m >= MOD); m_acc <= sum_m % MOD; e_clk <= 0;
      end else if (ph == HALF - 1) e_clk <= 1;
      e_req <= bnd_m;
      e_und <= bnd_m && !m_full && m_run;
      if (bnd_m && m_full) begin m_cur <= m_buf; m_run <= 1; end
      if (acc_m) m_buf <= int'($signed(bus.s_data));
      m_full <= full_n; e_ready <= !full_n; m_t <= m_t + 1;
    end
  end

  int n_cmp = 0, n_bad = 0, ncyc = 0;
  int w_ones = 0, w_n = 0, w_brk = 0, last_ones = 0, last_n = 0, last_brk = 0;
  int req_cnt = 0, und_cnt = 0, und_gap = 0, last_und = 0;
  bit prev_clk = 0, prev_bit = 0, neg_ready = 0, neg_req = 0;

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // One clock: compare all outputs at the falling edge, gather window stats, step past the rising edge.
  task automatic cyc();
    logic [5:0] got, exp;
    @(negedge HCLK);
    ncyc++;
    got = {bus.s_ready, bus.sample_req, bus.underrun, pdm_out, pdm_clk, aud_sd};
    exp = {e_ready, e_req, e_und, e_pdm, e_clk, e_aud};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL outputs cycle %0d: got rdy/req/und/pdm/clk/aud=%b required %b", ncyc, got, exp);
    end
    neg_ready = bus.s_ready;
    neg_req   = bus.sample_req;
    if (pdm_clk && !prev_clk) begin
      if (pdm_out) w_ones++;
      if (w_n > 0 && pdm_out == prev_bit) w_brk++;
      prev_bit = pdm_out;
      w_n++;
    end
    prev_clk = pdm_clk;
    if (bus.sample_req) begin
      last_ones = w_ones; last_n = w_n; last_brk = w_brk;
      w_ones = 0; w_n = 0; w_brk = 0;
      req_cnt++;
    end
    if (bus.underrun) begin
      und_gap = ncyc - last_und; last_und = ncyc; und_cnt++;
    end
    @(posedge HCLK);
    #1;
    if (ncyc > LIMIT) begin
      n_bad++;
      $display("FAIL watchdog: cycle %0d exceeded, required below %0d", ncyc, LIMIT);
      finish_run();
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit ok;
    int c;
    ok = 0; c = 0;
    bus.s_data = d; bus.s_valid = 1'b1;
    while (!ok && c < 2 * SPER) begin cyc(); ok = neg_ready; c++; end
    bus.s_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: data %h not accepted, required within %0d cycles", d, 2 * SPER);
    end
  endtask

  task automatic wait_req(input int n);
    int got, c;
    got = 0; c = 0;
    while (got < n && c < (n + 1) * SPER) begin cyc(); if (neg_req) got++; c++; end
    if (got < n) begin
      n_cmp++; n_bad++;
      $display("FAIL req_timeout: saw %0d sample_req, required %0d", got, n);
    end
  endtask

  initial begin
    int und0, req0, r;
    logic [DW-1:0] d;
    bus.s_data = '0; bus.s_valid = 1'b0;
    #1;
    repeat (3) cyc();
    check("reset_outputs", {26'd0, bus.s_ready, bus.sample_req, bus.underrun, pdm_out, pdm_clk, aud_sd}, 0);
    HRESETn = 1'b1; EN = 1'b1;
    repeat (2) cyc();
    check("ready_after_reset", bus.s_ready, 1);

    // Midscale: exactly 16 ones per 32 bits, strictly alternating.
    send(16'h0000); send(16'h0000); wait_req(2);
    check("zero_bits", last_n, 32);
    check("zero_ones", last_ones, 16);
    check("zero_alternation", last_brk, 0);

    send(16'h8000); send(16'h8000); wait_req(2);
    check("min_ones", last_ones, 0);
    send(16'h7FFF); send(16'h7FFF); wait_req(2);
    check("max_ones_ge31", last_ones >= 31, 1);

    // Back-to-back stream: one accept per boundary, no underrun.
    und0 = und_cnt; req0 = req_cnt;
    send(16'h1000); send(16'h2000); send(16'h3000); wait_req(1);
    check("stream_reqs", req_cnt - req0, 3);
    check("stream_no_underrun", und_cnt - und0, 0);

    // Starved: 0x3000 repeats (22 ones per window), underrun once per sample period.
    und0 = und_cnt;
    wait_req(3);
    check("underrun_count", und_cnt - und0, 3);
    check("underrun_period", und_gap, SPER);
    check("repeat_ones", last_ones, 22);

    // Drop EN inside bit 10, then re-enable into PRIME from a cleared accumulator.
    repeat (10 * D + 5) cyc();
    EN = 1'b0;
    cyc();
    check("en_drop_pdm", pdm_out, 0);
    check("en_drop_aud", aud_sd, 0);
    check("en_drop_ready", bus.s_ready, 0);
    repeat (5) cyc();
    EN = 1'b1;
    cyc();
    repeat (D) cyc();
    check("prime_bit0", pdm_out, 0);
    repeat (D) cyc();
    check("prime_bit1", pdm_out, 1);
    check("prime_ready", bus.s_ready, 1);

    // Asynchronous reset while running.
    HRESETn = 1'b0;
    #1;
    check("async_reset", {26'd0, bus.s_ready, bus.sample_req, bus.underrun, pdm_out, pdm_clk, aud_sd}, 0);
    repeat (2) cyc();
    HRESETn = 1'b1;
    repeat (2) cyc();
    check("ready_after_midrun_reset", bus.s_ready, 1);

    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, SPER / 4)) cyc();
      if ($urandom_range(0, 5) == 0) begin
        EN = 1'b0;
        repeat ($urandom_range(1, 4)) cyc();
        EN = 1'b1;
      end
      r = $urandom_range(0, 3);
      d = (r == 0) ? 16'h8000 : (r == 1) ? 16'h7FFF : 16'($urandom);
      send(d);
    end
    repeat (2 * SPER) cyc();
    finish_run();
  end

endmodule
